// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with valid/ready handshake; fixed (highest index wins) or round-robin priority.
// Define PRIO_ENC_GRANT_EN to add the registered one-hot out_grant output.
module priority_encoder_rr #(
   parameter  int N  = 8,
   parameter  int RR = 0,
   localparam int W  = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_found
`ifdef PRIO_ENC_GRANT_EN
   ,
   output logic [N-1:0] out_grant
`endif
);

   localparam logic [W-1:0] PTR_RST = W'(N - 1);

   logic         r_valid;
   logic [W-1:0] r_idx;
   logic         r_found;
   logic [W-1:0] r_ptr;
   logic         w_accept;
   logic         w_found;
   logic [W-1:0] w_win_idx;
   logic [W-1:0] w_ptr_nxt;

   // Position k steps below ptr, wrapping N-1 -> 0 without needing N to be a power of two.
   function automatic logic [W-1:0] rr_pos(input logic [W-1:0] ptr, input int k);
      int p;
      p = int'(ptr) - k;
      if (p < 0) p = p + N;
      return W'(p);
   endfunction

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Later loop iterations overwrite earlier ones, so the last set bit visited wins.
   always_comb begin
      // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
      w_win_idx = '0;
      w_found   = 1'b0;
      if (RR != 0) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (in_req[rr_pos(r_ptr, k)]) begin
               w_win_idx = rr_pos(r_ptr, k);
               w_found   = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (in_req[i]) begin
               w_win_idx = W'(i);
               w_found   = 1'b1;
            end
         end
      end
   end

   // The winner drops to lowest priority: the pointer moves to the index just below it.
   assign w_ptr_nxt = (w_win_idx == '0) ? PTR_RST : (w_win_idx - 1'b1);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_found <= 1'b0;
         r_ptr   <= PTR_RST;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_ptr   <= PTR_RST;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_idx   <= w_win_idx;
         r_found <= w_found;
         if ((RR != 0) && w_found) r_ptr <= w_ptr_nxt;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

`ifdef PRIO_ENC_GRANT_EN
   logic [N-1:0] r_grant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant <= '0;
      end else if (!flush && w_accept) begin
         r_grant <= w_found ? (N'(1) << w_win_idx) : '0;
      end
   end

   assign out_grant = r_grant;
`endif

   assign out_valid = r_valid;
   assign out_idx   = r_idx;
   assign out_found = r_found;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: one fixed-priority instance (N=8) and one round-robin instance (N=5).
module tb_priority_encoder_rr;

   logic       clk = 1'b0;
   logic       reset_n;

   logic       f_flush, f_in_valid, f_out_ready;
   logic [7:0] f_in_req;
   logic       f_in_ready, f_out_valid, f_out_found;
   logic [2:0] f_out_idx;

   logic       r_flush, r_in_valid, r_out_ready;
   logic [4:0] r_in_req;
   logic       r_in_ready, r_out_valid, r_out_found;
   logic [2:0] r_out_idx;

`ifdef PRIO_ENC_GRANT_EN
   logic [7:0] f_out_grant;
   logic [4:0] r_out_grant;
`endif

   priority_encoder_rr #(.N(8), .RR(0)) dut_fix (
      .clk(clk), .reset_n(reset_n), .flush(f_flush),
      .in_valid(f_in_valid), .in_ready(f_in_ready), .in_req(f_in_req),
      .out_valid(f_out_valid), .out_ready(f_out_ready),
      .out_idx(f_out_idx), .out_found(f_out_found)
`ifdef PRIO_ENC_GRANT_EN
      , .out_grant(f_out_grant)
`endif
   );

   priority_encoder_rr #(.N(5), .RR(1)) dut_rr (
      .clk(clk), .reset_n(reset_n), .flush(r_flush),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_req(r_in_req),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .out_idx(r_out_idx), .out_found(r_out_found)
`ifdef PRIO_ENC_GRANT_EN
      , .out_grant(r_out_grant)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic [2:0] idx;
      logic       found;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t fix_tab[6];
   vec_t rr_tab[11];

   initial begin
      fix_tab[0] = '{8'b0010_0110, 3'd5, 1'b1};
      fix_tab[1] = '{8'h80,        3'd7, 1'b1};
      fix_tab[2] = '{8'h01,        3'd0, 1'b1};
      fix_tab[3] = '{8'h00,        3'd0, 1'b0};
      fix_tab[4] = '{8'hFF,        3'd7, 1'b1};
      fix_tab[5] = '{8'b0001_1000, 3'd4, 1'b1};

      // Round-robin, N=5, ptr starts at 4.
      rr_tab[0]  = '{8'h1F, 3'd4, 1'b1};
      rr_tab[1]  = '{8'h1F, 3'd3, 1'b1};
      rr_tab[2]  = '{8'h1F, 3'd2, 1'b1};
      rr_tab[3]  = '{8'h1F, 3'd1, 1'b1};
      rr_tab[4]  = '{8'h1F, 3'd0, 1'b1};
      rr_tab[5]  = '{8'h1F, 3'd4, 1'b1};
      rr_tab[6]  = '{8'h05, 3'd2, 1'b1};
      rr_tab[7]  = '{8'h05, 3'd0, 1'b1};
      rr_tab[8]  = '{8'h05, 3'd2, 1'b1};
      rr_tab[9]  = '{8'h00, 3'd0, 1'b0};
      rr_tab[10] = '{8'h1F, 3'd1, 1'b1};

      reset_n = 1'b0;
      f_flush = 0; f_in_valid = 0; f_out_ready = 1; f_in_req = '0;
      r_flush = 0; r_in_valid = 0; r_out_ready = 1; r_in_req = '0;
      #12;
      check("reset_out_valid", {31'd0, f_out_valid}, 0);
      check("reset_out_idx",   {29'd0, f_out_idx}, 0);
      check("reset_out_found", {31'd0, f_out_found}, 0);
      check("reset_in_ready",  {31'd0, f_in_ready}, 1);
      check("reset_rr_valid",  {31'd0, r_out_valid}, 0);
      reset_n = 1'b1;
      step();

      // Fixed priority, back-to-back with out_ready held high.
      for (int i = 0; i < 6; i++) begin
         f_in_valid = 1'b1;
         f_in_req   = fix_tab[i].req;
         check($sformatf("fix_in_ready[%0d]", i), {31'd0, f_in_ready}, 1);
         step();
         check($sformatf("fix_valid[%0d]", i), {31'd0, f_out_valid}, 1);
         check($sformatf("fix_idx[%0d]", i),   {29'd0, f_out_idx}, {29'd0, fix_tab[i].idx});
         check($sformatf("fix_found[%0d]", i), {31'd0, f_out_found}, {31'd0, fix_tab[i].found});
`ifdef PRIO_ENC_GRANT_EN
         check($sformatf("fix_grant[%0d]", i), {24'd0, f_out_grant},
               fix_tab[i].found ? (32'd1 << fix_tab[i].idx) : 32'd0);
`endif
      end
      f_in_valid = 1'b0;

      // Round-robin rotation, reuse of ptr after a winner, and empty request leaving ptr alone.
      for (int i = 0; i < 11; i++) begin
         r_in_valid = 1'b1;
         r_in_req   = rr_tab[i].req[4:0];
         step();
         check($sformatf("rr_valid[%0d]", i), {31'd0, r_out_valid}, 1);
         check($sformatf("rr_idx[%0d]", i),   {29'd0, r_out_idx}, {29'd0, rr_tab[i].idx});
         check($sformatf("rr_found[%0d]", i), {31'd0, r_out_found}, {31'd0, rr_tab[i].found});
`ifdef PRIO_ENC_GRANT_EN
         check($sformatf("rr_grant[%0d]", i), {27'd0, r_out_grant},
               rr_tab[i].found ? (32'd1 << rr_tab[i].idx) : 32'd0);
`endif
      end
      r_in_valid = 1'b0;
      step();
      check("rr_drain_valid", {31'd0, r_out_valid}, 0);
      check("rr_drain_idx_hold", {29'd0, r_out_idx}, 1);

      // Stall: result idx=3 held while out_ready=0; new request ignored.
      f_in_valid = 1'b1; f_in_req = 8'h08;
      step();
      check("stall_first_idx", {29'd0, f_out_idx}, 3);
      f_out_ready = 1'b0; f_in_req = 8'h80;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall_in_ready[%0d]", c), {31'd0, f_in_ready}, 0);
         step();
         check($sformatf("stall_valid[%0d]", c), {31'd0, f_out_valid}, 1);
         check($sformatf("stall_idx[%0d]", c),   {29'd0, f_out_idx}, 3);
      end
      f_out_ready = 1'b1;
      #1;
      check("stall_release_ready", {31'd0, f_in_ready}, 1);
      step();
      check("stall_next_idx", {29'd0, f_out_idx}, 7);
      f_in_valid = 1'b0;
      step();
      check("drain_valid", {31'd0, f_out_valid}, 0);
      check("drain_idx_hold", {29'd0, f_out_idx}, 7);

      // Flush dominates a simultaneous accept and resets the RR pointer (ptr is 0 here).
      r_in_valid = 1'b1; r_in_req = 5'h1F; r_flush = 1'b1;
      #1;
      check("flush_in_ready", {31'd0, r_in_ready}, 1);
      step();
      check("flush_valid", {31'd0, r_out_valid}, 0);
      check("flush_idx_hold", {29'd0, r_out_idx}, 1);
      r_flush = 1'b0;
      step();
      check("flush_ptr_reset", {29'd0, r_out_idx}, 4);
      r_in_valid = 1'b0;

      // Reset pulse mid-stall clears outputs without waiting for a clock edge.
      f_in_valid = 1'b1; f_in_req = 8'h20;
      step();
      check("pre_reset_idx", {29'd0, f_out_idx}, 5);
      f_in_valid = 1'b0; f_out_ready = 1'b0;
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, f_out_valid}, 0);
      check("async_rst_idx",   {29'd0, f_out_idx}, 0);
      check("async_rst_found", {31'd0, f_out_found}, 0);
      check("async_rst_rr_idx", {29'd0, r_out_idx}, 0);
      #3;
      reset_n = 1'b1;
      f_out_ready = 1'b1;
      step();
      // RR ptr was 3 before reset; reset returns it to 4.
      r_in_valid = 1'b1; r_in_req = 5'h1F;
      step();
      check("rr_after_reset_idx", {29'd0, r_out_idx}, 4);
      r_in_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
